// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maze_pkg
//  Description : Shared direction codes and cell-index helper for the maze
//                player-position tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

   // Move direction codes carried on move_dir; codes 4..7 all mean "no move"
   localparam logic [2:0] DIR_UP    = 3'd0;
   localparam logic [2:0] DIR_DOWN  = 3'd1;
   localparam logic [2:0] DIR_RIGHT = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_NONE  = 3'd4;

   // Row-major bit index of cell (x,y) in the wall bitmap
   function automatic int cell_index(input int x, input int y, input int grid_w);
      return y * grid_w + x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/player_mover_if.sv
`default_nettype none
// ============================================================================
//  Module      : player_mover_if
//  Description : Move-request handshake, wall-map write port and position
//                status bundle between the direction decoder, the tracker
//                and the position display.
//  Revision    : 1.0 - initial release
// ============================================================================
interface player_mover_if #(
   parameter int X_W   = 3,
   parameter int Y_W   = 2,
   parameter int CNT_W = 8
);
   logic             move_valid;
   logic             move_ready;
   logic [2:0]       move_dir;
   logic             wall_we;
   logic [X_W-1:0]   wall_x;
   logic [Y_W-1:0]   wall_y;
   logic             wall_set;
   logic [X_W-1:0]   pos_x;
   logic [Y_W-1:0]   pos_y;
   logic             move_done;
   logic             move_blocked;
   logic [CNT_W-1:0] step_count;

   // Requester side: issues moves and wall edits, observes position
   modport master (
      output move_valid, move_dir, wall_we, wall_x, wall_y, wall_set,
      input  move_ready, pos_x, pos_y, move_done, move_blocked, step_count
   );

   // Tracker side
   modport slave (
      input  move_valid, move_dir, wall_we, wall_x, wall_y, wall_set,
      output move_ready, pos_x, pos_y, move_done, move_blocked, step_count
   );
endinterface
`default_nettype wire

// File: rtl/maze_map.sv
`default_nettype none
// ============================================================================
//  Module      : maze_map
//  Description : Run-time writable wall bitmap, one bit per cell, with a
//                single write port and a combinational read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module maze_map #(
   parameter int           N     = 32,
   parameter int           IDX_W = 5,
   parameter logic [N-1:0] INIT  = '0
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_we,
   input  wire logic [IDX_W-1:0] i_widx,
   input  wire logic             i_wdata,
   input  wire logic [IDX_W-1:0] i_ridx,
   output logic                  o_rdata
);

   logic [N-1:0] r_map;

   // Wall bits: reload the power-on maze on reset, single-bit edits afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_map <= INIT;
      end else if (i_we) begin
         r_map[i_widx] <= i_wdata;
      end
   end

   assign o_rdata = r_map[i_ridx];

endmodule
`default_nettype wire

// File: rtl/player_mover.sv
`default_nettype none
// ============================================================================
//  Module      : player_mover
//  Description : Registered player-position tracker. Accepts one move per
//                handshake, checks the candidate cell against grid edges and
//                the wall map, commits legal moves and counts steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_mover
   import maze_pkg::*;
#(
   parameter int                       GRID_W    = 8,
   parameter int                       GRID_H    = 4,
   parameter int                       X_W       = 3,
   parameter int                       Y_W       = 2,
   parameter int                       START_X   = 0,
   parameter int                       START_Y   = 0,
   parameter int                       WRAP      = 0,
   parameter int                       CNT_W     = 8,
   parameter logic [GRID_W*GRID_H-1:0] WALL_INIT = 32'h44451048
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   player_mover_if.slave bus
);

   localparam int N     = GRID_W * GRID_H;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CHECK  = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]       r_state;
   logic [2:0]       r_dir;
   logic [X_W-1:0]   r_pos_x;
   logic [Y_W-1:0]   r_pos_y;
   logic [X_W-1:0]   r_cand_x;
   logic [Y_W-1:0]   r_cand_y;
   logic             r_move;
   logic             r_blocked;
   logic             r_done;
   logic             r_blk_out;
   logic [CNT_W-1:0] r_count;

   int               w_cx;
   int               w_cy;
   logic             w_off;
   logic             w_none;
   logic [X_W-1:0]   w_cand_x;
   logic [Y_W-1:0]   w_cand_y;
   logic [IDX_W-1:0] w_cand_idx;
   logic             w_cell_wall;
   logic             w_wr_in_range;
   logic             w_wr_on_player;
   logic             w_map_we;
   logic [IDX_W-1:0] w_widx;

   // Candidate cell from the latched direction; edge crossings either wrap
   // modulo the grid size or are flagged as off-grid
   always_comb begin
      w_cx   = int'(r_pos_x);
      w_cy   = int'(r_pos_y);
      w_off  = 1'b0;
      w_none = 1'b0;
      case (r_dir)
         DIR_UP: begin
            if (w_cy == 0) begin
               if (WRAP != 0) w_cy = GRID_H - 1;
               else           w_off = 1'b1;
            end else begin
               w_cy = w_cy - 1;
            end
         end
         DIR_DOWN: begin
            if (w_cy == GRID_H - 1) begin
               if (WRAP != 0) w_cy = 0;
               else           w_off = 1'b1;
            end else begin
               w_cy = w_cy + 1;
            end
         end
         DIR_RIGHT: begin
            if (w_cx == GRID_W - 1) begin
               if (WRAP != 0) w_cx = 0;
               else           w_off = 1'b1;
            end else begin
               w_cx = w_cx + 1;
            end
         end
         DIR_LEFT: begin
            if (w_cx == 0) begin
               if (WRAP != 0) w_cx = GRID_W - 1;
               else           w_off = 1'b1;
            end else begin
               w_cx = w_cx - 1;
            end
         end
         default: w_none = 1'b1;
      endcase
      w_cand_x   = X_W'(w_cx);
      w_cand_y   = Y_W'(w_cy);
      w_cand_idx = IDX_W'(cell_index(w_cx, w_cy, GRID_W));
   end

   // Wall edits: drop out-of-grid targets and never wall in the player's cell
   assign w_wr_in_range  = (int'(bus.wall_x) < GRID_W) && (int'(bus.wall_y) < GRID_H);
   assign w_wr_on_player = (bus.wall_x == r_pos_x) && (bus.wall_y == r_pos_y);
   assign w_map_we       = bus.wall_we && w_wr_in_range && !(bus.wall_set && w_wr_on_player);
   assign w_widx         = IDX_W'(cell_index(int'(bus.wall_x), int'(bus.wall_y), GRID_W));

   maze_map #(
      .N     (N),
      .IDX_W (IDX_W),
      .INIT  (WALL_INIT)
   ) u_map (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_map_we),
      .i_widx  (w_widx),
      .i_wdata (bus.wall_set),
      .i_ridx  (w_cand_idx),
      .o_rdata (w_cell_wall)
   );

   // Request sequencing and verdict capture: IDLE -> CHECK -> COMMIT -> IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_dir     <= DIR_NONE;
         r_cand_x  <= '0;
         r_cand_y  <= '0;
         r_move    <= 1'b0;
         r_blocked <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.move_valid) begin
                  r_dir   <= bus.move_dir;
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               // Map read reflects writes up to, but not including, this edge
               r_cand_x  <= w_cand_x;
               r_cand_y  <= w_cand_y;
               r_move    <= !w_none && !w_off && !w_cell_wall;
               r_blocked <= !w_none && (w_off || w_cell_wall);
               r_state   <= S_COMMIT;
            end
            S_COMMIT: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // Position commit, done/blocked pulses and saturating step counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos_x   <= X_W'(START_X);
         r_pos_y   <= Y_W'(START_Y);
         r_done    <= 1'b0;
         r_blk_out <= 1'b0;
         r_count   <= '0;
      end else begin
         r_done    <= (r_state == S_COMMIT);
         r_blk_out <= (r_state == S_COMMIT) && r_blocked;
         if ((r_state == S_COMMIT) && r_move) begin
            r_pos_x <= r_cand_x;
            r_pos_y <= r_cand_y;
            if (r_count != {CNT_W{1'b1}}) begin
               r_count <= r_count + CNT_W'(1);
            end
         end
      end
   end

   assign bus.move_ready   = (r_state == S_IDLE);
   assign bus.pos_x        = r_pos_x;
   assign bus.pos_y        = r_pos_y;
   assign bus.move_done    = r_done;
   assign bus.move_blocked = r_blk_out;
   assign bus.step_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_player_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_mover
//  Description : Self-checking bench for player_mover. Two instances share
//                one stimulus stream: dut0 blocks at edges with an 8-bit
//                counter, dut1 wraps with a 2-bit counter. A transaction-level
//                reference model predicts every cycle; a directed table and
//                hand sequences pin the documented corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_mover;
   import maze_pkg::*;

   localparam int GW = 8;
   localparam int GH = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       t_valid;
   logic [2:0] t_dir;
   logic       t_we;
   logic [2:0] t_wx;
   logic [1:0] t_wy;
   logic       t_wset;

   always #5 clk = ~clk;

   player_mover_if #(.X_W(3), .Y_W(2), .CNT_W(8)) if0 ();
   player_mover_if #(.X_W(3), .Y_W(2), .CNT_W(2)) if1 ();

   assign if0.move_valid = t_valid;
   assign if0.move_dir   = t_dir;
   assign if0.wall_we    = t_we;
   assign if0.wall_x     = t_wx;
   assign if0.wall_y     = t_wy;
   assign if0.wall_set   = t_wset;
   assign if1.move_valid = t_valid;
   assign if1.move_dir   = t_dir;
   assign if1.wall_we    = t_we;
   assign if1.wall_x     = t_wx;
   assign if1.wall_y     = t_wy;
   assign if1.wall_set   = t_wset;

   player_mover #(
      .GRID_W(8), .GRID_H(4), .X_W(3), .Y_W(2), .START_X(0), .START_Y(0),
      .WRAP(0), .CNT_W(8), .WALL_INIT(32'h44451048)
   ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

   player_mover #(
      .GRID_W(8), .GRID_H(4), .X_W(3), .Y_W(2), .START_X(0), .START_Y(0),
      .WRAP(1), .CNT_W(2), .WALL_INIT(32'h44451048)
   ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   // ---------------- reference model ----------------
   // age: -1 idle, 0 = accepted last edge (check next), 1 = verdict known (finish next)
   int mx[2], my[2], mcnt[2], age[2], pdir[2], pkind[2], ptx[2], pty[2];
   bit mdone[2], mblk[2];
   bit mmap[2][32];
   int tests = 0;
   int fails = 0;

   function automatic void model_reset();
      logic [31:0] im;
      im = 32'h44451048;
      for (int d = 0; d < 2; d++) begin
         mx[d] = 0; my[d] = 0; mcnt[d] = 0; age[d] = -1;
         mdone[d] = 1'b0; mblk[d] = 1'b0; pkind[d] = 0;
         for (int i = 0; i < 32; i++) mmap[d][i] = im[i];
      end
   endfunction

   // Predict the effect of the coming clock edge given the current inputs
   function automatic void model_step();
      for (int d = 0; d < 2; d++) begin
         int nx, ny, nc, tx, ty, dx, dy, cmax;
         bit nd, nb;
         nx = mx[d]; ny = my[d]; nc = mcnt[d]; nd = 1'b0; nb = 1'b0;
         cmax = (d == 1) ? 3 : 255;
         if (age[d] == 1) begin
            nd = 1'b1;
            if (pkind[d] == 2) nb = 1'b1;
            else if (pkind[d] == 1) begin
               nx = ptx[d]; ny = pty[d];
               if (nc < cmax) nc = nc + 1;
            end
         end
         if (age[d] == 0) begin
            dx = 0; dy = 0;
            case (pdir[d])
               0: dy = -1;
               1: dy = 1;
               2: dx = 1;
               3: dx = -1;
               default: ;
            endcase
            if (pdir[d] > 3) pkind[d] = 0;
            else begin
               tx = mx[d] + dx; ty = my[d] + dy; pkind[d] = 1;
               if (tx < 0 || tx >= GW || ty < 0 || ty >= GH) begin
                  if (d == 1) begin tx = (tx + GW) % GW; ty = (ty + GH) % GH; end
                  else pkind[d] = 2;
               end
               if (pkind[d] == 1 && mmap[d][ty*GW+tx]) pkind[d] = 2;
               ptx[d] = tx; pty[d] = ty;
            end
         end
         if (t_we) begin
            tx = int'(t_wx); ty = int'(t_wy);
            if (tx < GW && ty < GH && !(t_wset && tx == mx[d] && ty == my[d]))
               mmap[d][ty*GW+tx] = t_wset;
         end
         if (age[d] == 0) age[d] = 1;
         else if (age[d] == 1) age[d] = -1;
         else if (t_valid) begin age[d] = 0; pdir[d] = int'(t_dir); end
         mx[d] = nx; my[d] = ny; mcnt[d] = nc; mdone[d] = nd; mblk[d] = nb;
      end
   endfunction

   task automatic chk(input string nm, input int d, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %0d, expected %0d", nm, d, act, exp);
      end
   endtask

   task automatic check_all();
      chk("pos_x",   0, int'(if0.pos_x),        mx[0]);
      chk("pos_y",   0, int'(if0.pos_y),        my[0]);
      chk("done",    0, int'(if0.move_done),    int'(mdone[0]));
      chk("blocked", 0, int'(if0.move_blocked), int'(mblk[0]));
      chk("count",   0, int'(if0.step_count),   mcnt[0]);
      chk("ready",   0, int'(if0.move_ready),   (age[0] < 0) ? 1 : 0);
      chk("pos_x",   1, int'(if1.pos_x),        mx[1]);
      chk("pos_y",   1, int'(if1.pos_y),        my[1]);
      chk("done",    1, int'(if1.move_done),    int'(mdone[1]));
      chk("blocked", 1, int'(if1.move_blocked), int'(mblk[1]));
      chk("count",   1, int'(if1.step_count),   mcnt[1]);
      chk("ready",   1, int'(if1.move_ready),   (age[1] < 0) ? 1 : 0);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_all();
   endtask

   // Accept, check, commit; leaves the done pulse visible on return
   task automatic do_move(input int dir, input int hold);
      t_valid = 1'b1;
      t_dir   = 3'(dir);
      tick();
      if (hold == 0) t_valid = 1'b0;
      tick();
      tick();
      t_valid = 1'b0;
   endtask

   task automatic do_wall(input int x, input int y, input int s);
      t_we = 1'b1; t_wx = 3'(x); t_wy = 2'(y); t_wset = s[0];
      tick();
      t_we = 1'b0;
   endtask

   task automatic chk_pos(input string nm, input int x0, input int y0, input int b0,
                          input int x1, input int y1, input int b1);
      chk({nm, "_x"},   0, int'(if0.pos_x), x0);
      chk({nm, "_y"},   0, int'(if0.pos_y), y0);
      chk({nm, "_blk"}, 0, int'(if0.move_blocked), b0);
      chk({nm, "_x"},   1, int'(if1.pos_x), x1);
      chk({nm, "_y"},   1, int'(if1.pos_y), y1);
      chk({nm, "_blk"}, 1, int'(if1.move_blocked), b1);
   endtask

   typedef struct packed {
      int kind;  // 0 move, 1 wall write
      int dir;
      int hold;
      int wx;
      int wy;
      int wset;
      int ex0; int ey0; int eb0; int ec0;
      int ex1; int ey1; int eb1; int ec1;
   } vec_t;

   vec_t tbl[12];

   initial begin
      t_valid = 1'b0; t_dir = 3'd4; t_we = 1'b0; t_wx = '0; t_wy = '0; t_wset = 1'b0;

      tbl[0]  = '{0, 2, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1};
      tbl[1]  = '{0, 2, 1, 0, 0, 0, 2, 0, 0, 2, 2, 0, 0, 2};
      tbl[2]  = '{0, 2, 0, 0, 0, 0, 2, 0, 1, 2, 2, 0, 1, 2};
      tbl[3]  = '{1, 0, 0, 3, 0, 0, 2, 0, 0, 2, 2, 0, 0, 2};
      tbl[4]  = '{0, 2, 0, 0, 0, 0, 3, 0, 0, 3, 3, 0, 0, 3};
      tbl[5]  = '{1, 0, 0, 3, 0, 1, 3, 0, 0, 3, 3, 0, 0, 3};
      tbl[6]  = '{0, 3, 0, 0, 0, 0, 2, 0, 0, 4, 2, 0, 0, 3};
      tbl[7]  = '{0, 2, 0, 0, 0, 0, 3, 0, 0, 5, 3, 0, 0, 3};
      tbl[8]  = '{0, 5, 0, 0, 0, 0, 3, 0, 0, 5, 3, 0, 0, 3};
      tbl[9]  = '{0, 0, 0, 0, 0, 0, 3, 0, 1, 5, 3, 3, 0, 3};
      tbl[10] = '{0, 1, 0, 0, 0, 0, 3, 1, 0, 6, 3, 0, 0, 3};
      tbl[11] = '{0, 2, 0, 0, 0, 0, 3, 1, 1, 6, 4, 0, 0, 3};

      do_reset();
      chk("rst_pos_x", 0, int'(if0.pos_x), 0);
      chk("rst_ready", 0, int'(if0.move_ready), 1);
      chk("rst_count", 1, int'(if1.step_count), 0);

      // Directed table
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].kind == 0) begin
            do_move(tbl[i].dir, tbl[i].hold);
            chk_pos($sformatf("tbl%0d", i), tbl[i].ex0, tbl[i].ey0, tbl[i].eb0,
                    tbl[i].ex1, tbl[i].ey1, tbl[i].eb1);
            chk($sformatf("tbl%0d_done", i), 0, int'(if0.move_done), 1);
            chk($sformatf("tbl%0d_done", i), 1, int'(if1.move_done), 1);
         end else begin
            do_wall(tbl[i].wx, tbl[i].wy, tbl[i].wset);
            chk($sformatf("tbl%0d_x", i), 0, int'(if0.pos_x), tbl[i].ex0);
            chk($sformatf("tbl%0d_x", i), 1, int'(if1.pos_x), tbl[i].ex1);
         end
         chk($sformatf("tbl%0d_cnt", i), 0, int'(if0.step_count), tbl[i].ec0);
         chk($sformatf("tbl%0d_cnt", i), 1, int'(if1.step_count), tbl[i].ec1);
         tick();
         tick();
      end

      // LEFT at the origin: blocked without wrap, lands on (7,0) with wrap
      do_reset();
      do_move(3, 0);
      chk_pos("left_edge", 0, 0, 1, 7, 0, 0);
      tick();

      // UP at the origin: blocked without wrap, lands on (0,3) with wrap
      do_reset();
      do_move(0, 0);
      chk_pos("up_edge", 0, 0, 1, 0, 3, 0);
      tick();

      // Reset while the request sits in CHECK: no pulse, start position
      do_reset();
      t_valid = 1'b1; t_dir = 3'd2;
      tick();
      t_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #2;
      chk("midrst_x", 0, int'(if0.pos_x), 0);
      chk("midrst_done", 0, int'(if0.move_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("midrst_after_x", 0, int'(if0.pos_x), 0);
      chk("midrst_after_cnt", 1, int'(if1.step_count), 0);

      // Wall raised on the target during CHECK is not seen by that check
      do_reset();
      t_valid = 1'b1; t_dir = 3'd2;
      tick();
      t_valid = 1'b0;
      t_we = 1'b1; t_wx = 3'd1; t_wy = 2'd0; t_wset = 1'b1;
      tick();
      t_we = 1'b0;
      tick();
      chk_pos("chk_write", 1, 0, 0, 1, 0, 0);
      tick();
      do_move(3, 0);
      do_move(2, 0);
      chk_pos("wall_after", 0, 0, 1, 0, 0, 1);
      tick();

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         t_valid = 1'($urandom_range(0, 1));
         t_dir   = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         t_we    = ($urandom_range(0, 4) == 0);
         t_wx    = 3'($urandom_range(0, 7));
         t_wy    = 2'($urandom_range(0, 3));
         t_wset  = ($urandom_range(0, 2) == 0);
         tick();
      end
      t_valid = 1'b0; t_we = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
